// File: rtl/reflet_float_divsqrt_if.sv
// Start/ready handshake and operand/result bundle for reflet_float_divsqrt.
// The master side issues operations and the slave side (the divide/sqrt unit) answers them.
interface reflet_float_divsqrt_if #(
    parameter int float_size = 32
);
    logic                  start;
    logic                  op;
    logic [float_size-1:0] flt_in1;
    logic [float_size-1:0] flt_in2;
    logic                  ready;
    logic                  done;
    logic [float_size-1:0] flt_out;
    logic [3:0]            flag_out;

    modport master (
        output start, op, flt_in1, flt_in2,
        input  ready, done, flt_out, flag_out
    );

    modport slave (
        input  start, op, flt_in1, flt_in2,
        output ready, done, flt_out, flag_out
    );
endinterface

// File: rtl/reflet_float_divsqrt.sv
// Iterative IEEE-754 divide / square root: one operation in flight, one result bit
// per cycle using restoring division/root, result truncated toward zero.
module reflet_float_divsqrt #(
    parameter int float_size = 32
) (
    input logic               clk,
    input logic               reset,
    input logic               enable,
    reflet_float_divsqrt_if.slave bus
);
    localparam int exp_size  = (float_size == 16) ? 5  : (float_size == 64) ? 11 : 8;
    localparam int mant_size = (float_size == 16) ? 10 : (float_size == 64) ? 52 : 23;
    localparam int M  = mant_size + 1;
    localparam int QW = mant_size + 3;
    localparam int RW = QW + 4;
    localparam int EW = exp_size + 2;
    localparam int CW = $clog2(QW);

    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (exp_size - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << exp_size) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic [float_size-2:0] INF_MAG = {{exp_size{1'b1}}, {mant_size{1'b0}}};
    localparam logic [float_size-1:0] QNAN    = {1'b0, {exp_size{1'b1}}, 1'b1, {(mant_size-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, UNPACK, ITER, PACK} state_t;

    state_t                 state;
    logic                   op_r;
    logic [float_size-1:0]  a_r, b_r;
    logic                   sign_r;
    logic signed [EW-1:0]   exp_r;
    logic [RW-1:0]          rem;
    logic [M-1:0]           dvs;
    logic [2*QW-1:0]        rad;
    logic [QW-1:0]          quo;
    logic [CW-1:0]          cnt;
    logic                   special;
    logic [float_size-1:0]  spec_res;
    logic [3:0]             spec_flags;

    // Saturate the biased exponent into infinity / flushed zero and assemble the word.
    function automatic logic [float_size+3:0] pack_result(input logic sign,
                                                          input logic signed [EW-1:0] e,
                                                          input logic [mant_size-1:0] m);
        if (e >= EXP_MAX)
            return {4'b0100, sign, INF_MAG};
        else if (e <= EXP_ZERO)
            return {4'b1000, sign, {(float_size-1){1'b0}}};
        return {4'b0000, sign, e[exp_size-1:0], m};
    endfunction

    logic                  s1, s2;
    logic [exp_size-1:0]   e1, e2;
    logic [mant_size-1:0]  f1, f2;
    logic                  zero1, zero2, inf1, inf2, nan1, nan2;
    logic signed [EW-1:0]  e1s, e2s, eu;
    logic                  spec_hit;
    logic [float_size-1:0] spec_val;
    logic [3:0]            spec_flg;

    assign s1 = a_r[float_size-1];
    assign s2 = b_r[float_size-1];
    assign e1 = a_r[float_size-2 -: exp_size];
    assign e2 = b_r[float_size-2 -: exp_size];
    assign f1 = a_r[mant_size-1:0];
    assign f2 = b_r[mant_size-1:0];
    // Subnormals fall into the zero class along with true zeros.
    assign zero1 = (e1 == '0);
    assign zero2 = (e2 == '0);
    assign inf1  = (&e1) && (f1 == '0);
    assign inf2  = (&e2) && (f2 == '0);
    assign nan1  = (&e1) && (f1 != '0);
    assign nan2  = (&e2) && (f2 != '0);
    assign e1s   = $signed({2'b00, e1});
    assign e2s   = $signed({2'b00, e2});
    assign eu    = e1s - BIAS;

    always_comb begin
        spec_hit = 1'b1;
        spec_val = '0;
        spec_flg = 4'b0000;
        if (!op_r) begin
            if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
                spec_val = QNAN;
                spec_flg = 4'b0001;
            end else if (zero2) begin
                spec_val = {s1 ^ s2, INF_MAG};
                spec_flg = 4'b0010;
            end else if (inf1)
                spec_val = {s1 ^ s2, INF_MAG};
            else if (inf2 || zero1)
                spec_val = {s1 ^ s2, {(float_size-1){1'b0}}};
            else
                spec_hit = 1'b0;
        end else begin
            if (nan1 || (s1 && !zero1)) begin
                spec_val = QNAN;
                spec_flg = 4'b0001;
            end else if (zero1)
                spec_val = {s1, {(float_size-1){1'b0}}};
            else if (inf1)
                spec_val = {1'b0, INF_MAG};
            else
                spec_hit = 1'b0;
        end
    end

    logic [RW-1:0] dvs_ext, sq_r, sq_t, rem_n;
    logic          bit_n;
    logic          norm;
    logic [mant_size-1:0] mant_fin;
    logic signed [EW-1:0] exp_fin;

    always_comb begin
        dvs_ext = {{(RW-M){1'b0}}, dvs};
        sq_r    = {rem[RW-3:0], rad[2*QW-1 -: 2]};
        sq_t    = {{(RW-QW-2){1'b0}}, quo, 2'b01};
        if (!op_r) begin
            bit_n = (rem >= dvs_ext);
            rem_n = (bit_n ? rem - dvs_ext : rem) << 1;
        end else begin
            bit_n = (sq_r >= sq_t);
            rem_n = bit_n ? sq_r - sq_t : sq_r;
        end
        // A divide quotient below 1.0 needs the single normalising left shift.
        norm     = !op_r && !quo[QW-1];
        mant_fin = norm ? quo[QW-3:1] : quo[QW-2:2];
        exp_fin  = exp_r - (norm ? EXP_ONE : EXP_ZERO);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            bus.ready    <= 1'b1;
            bus.done     <= 1'b0;
            bus.flt_out  <= '0;
            bus.flag_out <= '0;
        end else if (enable) begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    op_r      <= bus.op;
                    a_r       <= bus.flt_in1;
                    b_r       <= bus.flt_in2;
                    bus.ready <= 1'b0;
                    state     <= UNPACK;
                end
                UNPACK: begin
                    cnt        <= '0;
                    quo        <= '0;
                    special    <= spec_hit;
                    spec_res   <= spec_val;
                    spec_flags <= spec_flg;
                    if (!op_r) begin
                        sign_r <= s1 ^ s2;
                        exp_r  <= e1s - e2s + BIAS;
                        rem    <= {{(RW-M){1'b0}}, 1'b1, f1};
                        dvs    <= {1'b1, f2};
                    end else begin
                        sign_r <= 1'b0;
                        exp_r  <= (eu >>> 1) + BIAS;
                        rem    <= '0;
                        // Odd unbiased exponent: double the radicand so the halved exponent is exact.
                        rad    <= eu[0] ? {1'b1, f1, 1'b0, {(2*QW-M-1){1'b0}}}
                                        : {1'b0, 1'b1, f1, {(2*QW-M-1){1'b0}}};
                    end
                    state <= spec_hit ? PACK : ITER;
                end
                ITER: begin
                    rem <= rem_n;
                    quo <= {quo[QW-2:0], bit_n};
                    rad <= rad << 2;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(QW - 1))
                        state <= PACK;
                end
                PACK: begin
                    if (special)
                        {bus.flag_out, bus.flt_out} <= {spec_flags, spec_res};
                    else
                        {bus.flag_out, bus.flt_out} <= pack_result(sign_r, exp_fin, mant_fin);
                    bus.done  <= 1'b1;
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
